alu_arbiter_sequencer: RTL

//  Shares one arithmetic_logic_unit instance between two requesters. Round-robin

---
 rtl/alu_arbiter_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/alu_arbiter_sequencer.sv
// alu_arbiter_sequencer: round-robin sharing of one ALU between two requesters with a registered response
module arithmetic_logic_unit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output logic [3:0]       flags_o,
  output logic             illegal_o
);
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     dif;
  logic [2*WIDTH-1:0] rot;
  logic [WIDTH-1:0]   ramt;
  logic               c;
  logic               v;
  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign dif  = {1'b0, a_i} + {1'b0, ~b_i} + (WIDTH+1)'(1);
  assign ramt = WIDTH'(b_i % WIDTH);
  assign rot  = {a_i, a_i} >> ramt;
  // Opcode decode; subtract carry is "no borrow" (carry out of a + ~b + 1)
  always_comb begin
    result_o  = '0;
    c         = 1'b0;
    v         = 1'b0;
    illegal_o = 1'b0;
    case (op_i)
      4'd0: result_o = a_i | b_i;
      4'd1: result_o = a_i ^ b_i;
      4'd2: result_o = a_i & b_i;
      4'd3: result_o = rot[WIDTH-1:0];
      4'd4: result_o = a_i >> b_i;
      4'd5: result_o = a_i << b_i;
      4'd8: begin
        result_o = sum[WIDTH-1:0];
        c        = sum[WIDTH];
        v        = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      4'd9: begin
        result_o = dif[WIDTH-1:0];
        c        = dif[WIDTH];
        v        = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (dif[WIDTH-1] != a_i[WIDTH-1]);
      end
      4'd10: result_o = $signed(a_i) >>> b_i;
      default: illegal_o = 1'b1;
    endcase
  end
  assign flags_o = {result_o[WIDTH-1], result_o == '0, c, v};
endmodule

module alu_arbiter_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic [3:0]       resp_flags,
  output logic             resp_err,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t           state_q;
  logic             last_grant_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       op_q;
  logic             id_q;
  logic             resp_valid_q;
  logic             resp_id_q;
  logic [WIDTH-1:0] resp_result_q;
  logic [3:0]       resp_flags_q;
  logic             resp_err_q;
  logic             grant;
  logic             pick1;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;
  logic             alu_illegal;
  // The ALU only ever sees the captured operands, never the live request ports
  arithmetic_logic_unit #(.WIDTH(WIDTH)) u_alu (
    .a_i       (a_q),
    .b_i       (b_q),
    .op_i      (op_q),
    .result_o  (alu_result),
    .flags_o   (alu_flags),
    .illegal_o (alu_illegal)
  );
  // On a tie the requester not granted last wins; readys are held low while in reset
  assign pick1      = req1_valid && (!req0_valid || !last_grant_q);
  assign grant      = rst_n && (state_q == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = grant && !pick1;
  assign req1_ready = grant && pick1;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;
  assign resp_flags  = resp_flags_q;
  assign resp_err    = resp_err_q;
  assign busy        = state_q != IDLE;
  // Sequencer: capture winner, execute once, hold response until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      id_q          <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
      resp_flags_q  <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (grant) begin
          a_q          <= pick1 ? req1_a : req0_a;
          b_q          <= pick1 ? req1_b : req0_b;
          op_q         <= pick1 ? req1_op : req0_op;
          id_q         <= pick1;
          last_grant_q <= pick1;
          state_q      <= EXEC;
        end
        EXEC: begin
          resp_result_q <= alu_illegal ? '0 : alu_result;
          resp_flags_q  <= alu_illegal ? '0 : alu_flags;
          resp_err_q    <= alu_illegal;
          resp_id_q     <= id_q;
          resp_valid_q  <= 1'b1;
          state_q       <= RESP;
        end
        RESP: if (resp_ready) begin
          resp_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
